// File: rtl/alu_addsub_seq_pkg.sv
// alu_addsub_seq_pkg: shared ALU constants for the sequential add/subtract unit.
package alu_addsub_seq_pkg;
    localparam int SLICE_W = 16;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/alu_addsub_seq_if.sv
// alu_addsub_seq_if: start/busy/done handshake, operands, result and condition flags.
interface alu_addsub_seq_if #(
    parameter int WIDTH = 32
);
    logic start, sub, busy, done;
    logic flag_c, flag_v, flag_n, flag_z;
    logic [WIDTH-1:0] A, B, result;
    modport master (
        output start, sub, A, B,
        input  busy, done, result, flag_c, flag_v, flag_n, flag_z
    );
    modport slave (
        input  start, sub, A, B,
        output busy, done, result, flag_c, flag_v, flag_n, flag_z
    );
endinterface

// File: rtl/alu_addsub_seq_cla16.sv
// alu_addsub_seq_cla16: 16-bit carry-lookahead adder built from four 4-bit groups.
module alu_addsub_seq_cla16
    import alu_addsub_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               g,
    output logic               p
);
    logic [SLICE_W-1:0] gi, pi, c;
    logic [3:0] gg, gp;
    logic [4:0] cg;
    always_comb begin
        gi = a & b;
        pi = a ^ b;
        cg[0] = cin;
        g = 1'b0;
        c = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = 1'b0;
            for (int j = 0; j < 4; j++) gg[k] = gi[4*k+j] | (pi[4*k+j] & gg[k]);
            gp[k] = &pi[4*k +: 4];
            cg[k+1] = gg[k] | (gp[k] & cg[k]);
            g = gg[k] | (gp[k] & g);
            c[4*k] = cg[k];
            for (int j = 1; j < 4; j++) c[4*k+j] = gi[4*k+j-1] | (pi[4*k+j-1] & c[4*k+j-1]);
        end
        p = &gp;
        sum = pi ^ c;
        cout = cg[4];
    end
endmodule

// File: rtl/alu_addsub_seq.sv
// alu_addsub_seq: multi-cycle add/subtract reusing one 16-bit CLA slice per cycle, LSB slice first.
// Define ADDSUB_FLAGS_EN to build the C/V/N/Z flag registers; otherwise the flags read 0.
module alu_addsub_seq
    import alu_addsub_seq_pkg::*;
#(
    parameter int NUM_SLICES = 2
) (
    input logic clock,
    input logic clear,
    alu_addsub_seq_if.slave bus
);
    localparam int IW = NUM_SLICES > 1 ? $clog2(NUM_SLICES) : 1;
    state_t state;
    logic [NUM_SLICES-1:0][SLICE_W-1:0] a_r, b_r, res, res_next;
    logic [IW-1:0] idx;
    logic carry, busy, done, cout, last;
    logic [SLICE_W-1:0] sum;

    alu_addsub_seq_cla16 u_cla (
        .a(a_r[idx]), .b(b_r[idx]), .cin(carry), .sum(sum), .cout(cout), .g(), .p()
    );

    always_comb begin
        res_next = res;
        res_next[idx] = sum;
    end
    assign last = state == RUN && idx == IW'(NUM_SLICES - 1);

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            res <= '0;
            idx <= '0;
            carry <= 1'b0;
            a_r <= '0;
            b_r <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_r <= bus.A;
                    b_r <= bus.sub == OP_SUB ? ~bus.B : bus.B;
                    carry <= bus.sub == OP_SUB;
                    idx <= '0;
                    busy <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    res <= res_next;
                    carry <= cout;
                    idx <= idx + 1'b1;
                    if (last) begin
                        done <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.result = res;

`ifdef ADDSUB_FLAGS_EN
    logic fc, fv, fn, fz;
    // flags are taken from the final slice's outputs as the unit enters DONE
    always_ff @(posedge clock) begin
        if (clear) begin
            {fc, fv, fn, fz} <= '0;
        end else if (last) begin
            fc <= cout;
            fv <= (a_r[NUM_SLICES-1][SLICE_W-1] == b_r[NUM_SLICES-1][SLICE_W-1]) &
                  (res_next[NUM_SLICES-1][SLICE_W-1] != a_r[NUM_SLICES-1][SLICE_W-1]);
            fn <= res_next[NUM_SLICES-1][SLICE_W-1];
            fz <= res_next == '0;
        end
    end
    assign bus.flag_c = fc;
    assign bus.flag_v = fv;
    assign bus.flag_n = fn;
    assign bus.flag_z = fz;
`else
    assign bus.flag_c = 1'b0;
    assign bus.flag_v = 1'b0;
    assign bus.flag_n = 1'b0;
    assign bus.flag_z = 1'b0;
`endif
endmodule

// File: tb/tb_alu_addsub_seq.sv
// tb_alu_addsub_seq: directed vectors for alu_addsub_seq checked against an arithmetic model.
module tb_alu_addsub_seq;
    localparam int N = 2;
    localparam int W = 16 * N;
    localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
    localparam longint MINS = -(longint'(1) << (W - 1));
`ifdef ADDSUB_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic clock = 1'b0;
    logic clear = 1'b1;
    alu_addsub_seq_if #(.WIDTH(W)) bus ();
    alu_addsub_seq #(.NUM_SLICES(N)) dut (.clock(clock), .clear(clear), .bus(bus));

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int dones = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: tracks the operation as a whole and computes its outcome with plain arithmetic.
    logic m_busy = 1'b0, m_done = 1'b0, m_sub = 1'b0;
    logic [W-1:0] m_res = '0, m_a = '0, m_b = '0;
    logic [3:0] m_f = '0;
    logic [W:0] m_sum;
    longint m_sr;
    int m_left = 0;

    always @(posedge clock) begin
        if (clear) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_res = '0;
            m_f = '0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_sr = m_sub ? longint'($signed(m_a)) - longint'($signed(m_b))
                             : longint'($signed(m_a)) + longint'($signed(m_b));
                m_sum = {1'b0, m_a} + {1'b0, m_b};
                m_res = W'(m_sr);
                m_f[3] = m_sub ? (m_a >= m_b) : m_sum[W];
                m_f[2] = m_sr > MAXS || m_sr < MINS;
                m_f[1] = m_res[W-1];
                m_f[0] = m_res == '0;
                m_f = m_f & {4{FL}};
                m_done = 1'b1;
            end
        end else if (bus.start) begin
            m_a = bus.A;
            m_b = bus.B;
            m_sub = bus.sub;
            m_left = N;
            m_busy = 1'b1;
        end
    end

    always @(negedge clock) begin
        chk("busy", bus.busy, m_busy);
        chk("done", bus.done, m_done);
        if (bus.done) dones++;
        if (!m_busy || m_done) begin
            chk("result", bus.result, m_res);
            chk("flags", {bus.flag_c, bus.flag_v, bus.flag_n, bus.flag_z}, m_f);
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        bus.A = a;
        bus.B = b;
        bus.sub = s;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    // latency counts the start cycle as cycle 0
    task automatic finish_chk(input string nm, input logic [W-1:0] er, input logic [3:0] ef);
        int lat = 1;
        while (!bus.done && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(N + 1));
        chk({nm, " result"}, bus.result, er);
        chk({nm, " flags"}, {bus.flag_c, bus.flag_v, bus.flag_n, bus.flag_z}, ef & {4{FL}});
    endtask

    task automatic op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic [W-1:0] er, input logic [3:0] ef);
        issue(a, b, s);
        finish_chk(nm, er, ef);
        @(negedge clock);
    endtask

    initial begin
        int d0;
        bus.start = 1'b0;
        bus.sub = 1'b0;
        bus.A = '0;
        bus.B = '0;
        repeat (3) @(negedge clock);
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset result", bus.result, 0);
        chk("reset flags", {bus.flag_c, bus.flag_v, bus.flag_n, bus.flag_z}, 0);
        clear = 1'b0;
        @(negedge clock);

        // flags literal order: C V N Z
        op("carry across slice", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 4'b0000);
        op("signed overflow", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0110);
        op("wrap to zero", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1001);
        op("5-7", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 4'b0010);
        op("7-5", 32'd7, 32'd5, 1'b1, 32'd2, 4'b1000);
        op("min-1", 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 4'b1100);
        op("0-0", 32'd0, 32'd0, 1'b1, 32'd0, 4'b1001);

        // start and operand changes during RUN are ignored
        d0 = dones;
        issue(32'h1234_5678, 32'h1111_1111, 1'b0);
        bus.A = 32'hDEAD_BEEF;
        bus.B = 32'h0BAD_F00D;
        bus.sub = 1'b1;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (8) @(negedge clock);
        chk("ignored start result", bus.result, 32'h2345_6789);
        chk("ignored start done count", 64'(dones - d0), 1);

        // start in the DONE cycle is ignored, accepted the cycle after
        issue(32'd3, 32'd4, 1'b0);
        finish_chk("b2b first", 32'd7, 4'b0000);
        bus.A = 32'd10;
        bus.B = 32'd3;
        bus.sub = 1'b1;
        bus.start = 1'b1;
        @(negedge clock);
        chk("done-cycle start ignored", bus.busy, 0);
        issue(32'd10, 32'd3, 1'b1);
        finish_chk("b2b second", 32'd7, 4'b1000);
        @(negedge clock);

        // clear in the first RUN cycle aborts the operation
        d0 = dones;
        issue(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("abort busy", bus.busy, 0);
        chk("abort result", bus.result, 0);
        chk("abort flags", {bus.flag_c, bus.flag_v, bus.flag_n, bus.flag_z}, 0);
        repeat (5) @(negedge clock);
        chk("abort no done", 64'(dones - d0), 0);
        op("after abort", 32'h0001_0002, 32'h0003_0004, 1'b0, 32'h0004_0006, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
